// File: rtl/axi_stream_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream round-robin arbiter.
package axi_stream_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DefaultNumRx     = 4;
    localparam int DefaultDataWidth = 32;

    // Index width of a port number, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_rr_arbiter_if.sv
// Bundle of NumPorts AXI4-Stream lanes (tvalid/tdata/tlast forward, tready back).
interface axi_stream_rr_arbiter_if #(
    parameter int NumPorts  = 1,
    parameter int DataWidth = 32
);
    logic [NumPorts-1:0]                tvalid;
    logic [NumPorts-1:0][DataWidth-1:0] tdata;
    logic [NumPorts-1:0]                tlast;
    logic [NumPorts-1:0]                tready;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_stream_rr_pick.sv
// Combinational round-robin picker: first set bit of req_mask at or above ptr, wrapping
// modulo NumPorts (not modulo a power of two).
module axi_stream_rr_pick
    import axi_stream_arb_pkg::*;
#(
    parameter  int NumPorts = DefaultNumRx,
    localparam int IdxWidth = idx_width(NumPorts)
) (
    input  logic [NumPorts-1:0] req_mask,
    input  logic [IdxWidth-1:0] ptr,
    output logic                any_o,
    output logic [IdxWidth-1:0] idx_o
);

    localparam int SumW = IdxWidth + 1;

    logic [SumW-1:0]     sum  [NumPorts];
    logic [IdxWidth-1:0] cand [NumPorts];
    logic [NumPorts-1:0] hit;

    // cand[gi] is the port visited gi steps after ptr in the rotated search order.
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rot
        assign sum[gi]  = {1'b0, ptr} + SumW'(gi);
        assign cand[gi] = (sum[gi] >= SumW'(NumPorts)) ? IdxWidth'(sum[gi] - SumW'(NumPorts))
                                                        : sum[gi][IdxWidth-1:0];
        assign hit[gi]  = req_mask[cand[gi]];
    end

    always_comb begin
        any_o = |hit;
        idx_o = ptr;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Merges NumRx AXI4-Stream ports onto one tx port with a registered round-robin grant,
// holding the grant for a whole packet when LockPackets is set.
module axi_stream_rr_arbiter
    import axi_stream_arb_pkg::*;
#(
    parameter  int NumRx       = DefaultNumRx,
    parameter  int DataWidth   = DefaultDataWidth,
    parameter  bit LockPackets = 1'b1,
    localparam int IdxWidth    = idx_width(NumRx)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    axi_stream_rr_arbiter_if.slave  rx,
    axi_stream_rr_arbiter_if.master tx,
    output logic [IdxWidth-1:0]     grant_o,
    output logic                    busy_o
);

    arb_state_e          state_reg, state_next;
    logic [IdxWidth-1:0] sel_reg, sel_next;
    logic [IdxWidth-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IdxWidth-1:0] sel_inc;

    logic                 locked;
    logic                 tx_valid, tx_last, release_evt;
    logic [DataWidth-1:0] tx_data;
    logic [NumRx-1:0]     sel_onehot, cand_mask;
    logic                 idle_any, cand_any;
    logic [IdxWidth-1:0]  idle_idx, cand_idx;

    assign locked  = (state_reg == LOCKED);
    assign sel_inc = (sel_reg == IdxWidth'(NumRx - 1)) ? '0 : sel_reg + IdxWidth'(1);

    // Only the granted port ever sees tready, and only while locked.
    for (genvar gi = 0; gi < NumRx; gi++) begin : g_port
        assign sel_onehot[gi] = (sel_reg == IdxWidth'(gi));
        assign rx.tready[gi]  = locked & sel_onehot[gi] & tx.tready[0];
    end

    assign tx_valid = locked & rx.tvalid[sel_reg];
    assign tx_last  = locked & rx.tlast[sel_reg];
    assign tx_data  = locked ? rx.tdata[sel_reg] : '0;

    assign tx.tvalid[0] = tx_valid;
    assign tx.tlast[0]  = tx_last;
    assign tx.tdata[0]  = tx_data;

    assign release_evt = tx_valid & tx.tready[0] & (tx_last | !LockPackets);

    // The granted port's tvalid describes the beat just consumed, so it is no candidate.
    assign cand_mask = rx.tvalid & ~sel_onehot;

    axi_stream_rr_pick #(
        .NumPorts (NumRx)
    ) u_pick_idle (
        .req_mask (rx.tvalid),
        .ptr      (rr_ptr_reg),
        .any_o    (idle_any),
        .idx_o    (idle_idx)
    );

    axi_stream_rr_pick #(
        .NumPorts (NumRx)
    ) u_pick_next (
        .req_mask (cand_mask),
        .ptr      (sel_inc),
        .any_o    (cand_any),
        .idx_o    (cand_idx)
    );

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (idle_any) begin
                    sel_next   = idle_idx;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (release_evt) begin
                    rr_ptr_next = sel_inc;
                    if (cand_any) begin
                        sel_next = cand_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign busy_o  = locked;
    assign grant_o = sel_reg;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and a
// randomized run compared against a last-served round-robin reference model.
module tb_axi_stream_rr_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       rv;
    logic [3:0]       rl;
    logic [3:0][31:0] rd;
    logic             txr;

    logic [1:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    axi_stream_rr_arbiter_if #(.NumPorts(4), .DataWidth(32)) rx_a ();
    axi_stream_rr_arbiter_if #(.NumPorts(1), .DataWidth(32)) tx_a ();
    axi_stream_rr_arbiter_if #(.NumPorts(4), .DataWidth(32)) rx_b ();
    axi_stream_rr_arbiter_if #(.NumPorts(1), .DataWidth(32)) tx_b ();

    assign rx_a.tvalid = rv;
    assign rx_a.tlast  = rl;
    assign rx_a.tdata  = rd;
    assign tx_a.tready = txr;
    assign rx_b.tvalid = rv;
    assign rx_b.tlast  = rl;
    assign rx_b.tdata  = rd;
    assign tx_b.tready = txr;

    axi_stream_rr_arbiter #(.NumRx(4), .DataWidth(32), .LockPackets(1'b1)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .rx      (rx_a),
        .tx      (tx_a),
        .grant_o (grant_a),
        .busy_o  (busy_a)
    );

    axi_stream_rr_arbiter #(.NumRx(4), .DataWidth(32), .LockPackets(1'b0)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .rx      (rx_b),
        .tx      (tx_b),
        .grant_o (grant_b),
        .busy_o  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ready;
        logic        exp_busy;
        logic [1:0]  exp_grant;
        logic        exp_txv;
        logic        exp_last;
        logic [31:0] exp_data;
        logic [3:0]  exp_tready;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv  = 4'b0000;
        rl  = 4'b0000;
        txr = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    // Samples DUT A at the falling edge; grant is only meaningful while busy.
    task automatic exp_a(input string tag, input logic eb, input logic [1:0] eg, input logic ev,
                         input logic el, input logic [31:0] ed, input logic [3:0] etr);
        @(negedge clk);
        $display("%0t %s: busy=%0d grant=%0d txv=%0d last=%0d data=%h tready=%b",
                 $time, tag, busy_a, grant_a, tx_a.tvalid[0], tx_a.tlast[0], tx_a.tdata[0],
                 rx_a.tready);
        chk({tag, " busy"}, 32'(busy_a), 32'(eb));
        if (eb) chk({tag, " grant"}, 32'(grant_a), 32'(eg));
        chk({tag, " txv"}, 32'(tx_a.tvalid[0]), 32'(ev));
        chk({tag, " tlast"}, 32'(tx_a.tlast[0]), 32'(el));
        chk({tag, " tdata"}, tx_a.tdata[0], ed);
        chk({tag, " tready"}, 32'(rx_a.tready), 32'(etr));
    endtask

    // Reference: first valid port among cnt ports visited from start, wrapping mod 4.
    function automatic int first_from(input logic [3:0] m, input int start, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            if (m[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    int         owner, lastsv;
    int         plen [4];
    int         pbeat[4];
    int         pno  [4];
    bit         inpkt[4];
    logic [3:0] fired;
    logic       eb, ev, el;
    logic [1:0] eg;
    logic [31:0] ed;
    logic [3:0] etr;
    int         cnt [2];
    int         b;

    initial begin
        rst = 1'b1; rv = 4'b1111; rl = 4'b0000; txr = 1'b1;
        for (int p = 0; p < 4; p++) rd[p] = 32'hDEAD_0000 + 32'(p);

        // Reset held with every producer valid.
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_a("reset", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);
            chk("reset grant", 32'(grant_a), 32'd0);
        end

        // Contention 0,1,3 with 2-beat packets, then rx3 served and rx0/rx3 race.
        tbl[0]  = '{4'b1011, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,  4'b0000};
        tbl[1]  = '{4'b1011, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'hC0, 4'b0001};
        tbl[2]  = '{4'b1011, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 32'hC0, 4'b0001};
        tbl[3]  = '{4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 32'hC1, 4'b0010};
        tbl[4]  = '{4'b1010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 32'hC1, 4'b0010};
        tbl[5]  = '{4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 32'hC3, 4'b1000};
        tbl[6]  = '{4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 32'hC3, 4'b1000};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,  4'b0000};
        tbl[8]  = '{4'b1001, 4'b1001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,  4'b0000};
        tbl[9]  = '{4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 32'hC0, 4'b0001};
        tbl[10] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 32'hC3, 4'b1000};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,  4'b0000};
        do_reset();
        for (int p = 0; p < 4; p++) rd[p] = 32'hC0 + 32'(p);
        for (int i = 0; i < 12; i++) begin
            rv = tbl[i].valid; rl = tbl[i].last; txr = tbl[i].ready;
            exp_a($sformatf("vec%0d", i), tbl[i].exp_busy, tbl[i].exp_grant, tbl[i].exp_txv,
                  tbl[i].exp_last, tbl[i].exp_data, tbl[i].exp_tready);
            cyc();
        end

        // Single port rx2, 3-beat packet.
        do_reset();
        rv = 4'b0100; rd[2] = 32'hA0; rl = 4'b0000;
        exp_a("single idle", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);
        cyc();
        for (int k = 0; k < 3; k++) begin
            rd[2] = 32'hA0 + 32'(k); rl[2] = (k == 2);
            exp_a("single beat", 1'b1, 2'd2, 1'b1, (k == 2), 32'hA0 + 32'(k), 4'b0100);
            cyc();
        end
        rv = 4'b0000;
        exp_a("single done", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);

        // Backpressure on rx1 with rx3 waiting; rx3 follows back-to-back.
        do_reset();
        rv = 4'b0010; rd[1] = 32'h50; rl = 4'b0000; txr = 1'b1;
        exp_a("bp idle", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);
        cyc();
        b = 0;
        rd[3] = 32'h77; rl[3] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            rv = 4'b1010; txr = (c % 2 == 0);
            rd[1] = 32'h50 + 32'(b); rl[1] = (b == 3);
            exp_a("bp beat", 1'b1, 2'd1, 1'b1, (b == 3), 32'h50 + 32'(b),
                  txr ? 4'b0010 : 4'b0000);
            cyc();
            if (txr) b++;
        end
        rv = 4'b1000; txr = 1'b1;
        exp_a("bp next", 1'b1, 2'd3, 1'b1, 1'b1, 32'h77, 4'b1000);
        cyc();
        rv = 4'b0000;
        exp_a("bp done", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);

        // Beat-level arbitration on DUT B: rx0/rx1 streams must alternate.
        do_reset();
        cnt[0] = 0; cnt[1] = 0;
        rv = 4'b0011; rl = 4'b0000; rd[0] = 32'h000; rd[1] = 32'h100;
        @(negedge clk);
        chk("beat idle busy", 32'(busy_b), 32'd0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            rd[0] = 32'h000 + 32'(cnt[0]);
            rd[1] = 32'h100 + 32'(cnt[1]);
            @(negedge clk);
            $display("%0t beat %0d: grant=%0d data=%h tready=%b", $time, k, grant_b,
                     tx_b.tdata[0], rx_b.tready);
            chk("beat busy", 32'(busy_b), 32'd1);
            chk("beat grant", 32'(grant_b), 32'(k % 2));
            chk("beat data", tx_b.tdata[0], 32'((k % 2) * 256 + cnt[k % 2]));
            chk("beat tready", 32'(rx_b.tready), 32'(1 << (k % 2)));
            cyc();
            cnt[k % 2]++;
        end

        // Reset in the middle of a 4-beat rx2 packet after rr pointer moved to 2.
        do_reset();
        rv = 4'b0010; rl = 4'b0010; rd[1] = 32'h11;
        exp_a("rstmid idle", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);
        cyc();
        exp_a("rstmid rx1", 1'b1, 2'd1, 1'b1, 1'b1, 32'h11, 4'b0010);
        cyc();
        rv = 4'b0100; rl = 4'b0000; rd[2] = 32'h20;
        exp_a("rstmid idle2", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);
        cyc();
        exp_a("rstmid beat0", 1'b1, 2'd2, 1'b1, 1'b0, 32'h20, 4'b0100);
        cyc();
        rd[2] = 32'h21; rst = 1'b1;
        exp_a("rstmid beat1", 1'b1, 2'd2, 1'b1, 1'b0, 32'h21, 4'b0100);
        cyc();
        rst = 1'b0; rv = 4'b0110;
        exp_a("rstmid after", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'b0000);
        chk("rstmid grant", 32'(grant_a), 32'd0);
        cyc();
        exp_a("rstmid ptr0", 1'b1, 2'd1, 1'b1, 1'b0, rd[1], 4'b0010);

        // Randomized producers checked against the last-served reference model.
        do_reset();
        owner = -1; lastsv = 3;
        for (int p = 0; p < 4; p++) begin
            plen[p] = 1; pbeat[p] = 0; pno[p] = 0; inpkt[p] = 1'b0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (owner >= 0) begin
                eb = 1'b1; eg = owner[1:0]; ev = rv[owner]; el = rl[owner]; ed = rd[owner];
                etr = txr ? (4'b0001 << owner) : 4'b0000;
            end else begin
                eb = 1'b0; eg = 2'd0; ev = 1'b0; el = 1'b0; ed = 32'h0; etr = 4'b0000;
            end
            chk("rnd busy", 32'(busy_a), 32'(eb));
            if (eb) chk("rnd grant", 32'(grant_a), 32'(eg));
            chk("rnd txv", 32'(tx_a.tvalid[0]), 32'(ev));
            chk("rnd tlast", 32'(tx_a.tlast[0]), 32'(el));
            chk("rnd tdata", tx_a.tdata[0], ed);
            chk("rnd tready", 32'(rx_a.tready), 32'(etr));
            fired = rv & rx_a.tready;
            if (owner < 0) begin
                owner = first_from(rv, (lastsv + 1) % 4, 4);
            end else if (ev && txr && el) begin
                lastsv = owner;
                owner  = first_from(rv, (lastsv + 1) % 4, 3);
            end
            cyc();
            for (int p = 0; p < 4; p++) begin
                if (fired[p]) begin
                    if (pbeat[p] == plen[p] - 1) begin
                        $display("%0t rand: port %0d packet %0d len %0d accepted", $time, p,
                                 pno[p], plen[p]);
                        inpkt[p] = 1'b0; pno[p]++; pbeat[p] = 0;
                    end else begin
                        pbeat[p]++;
                    end
                end
                if (fired[p] || !rv[p]) begin
                    if (inpkt[p]) begin
                        rv[p] = ($urandom_range(4) != 0);
                    end else if ($urandom_range(1) == 1) begin
                        inpkt[p] = 1'b1; plen[p] = 1 + $urandom_range(3); pbeat[p] = 0;
                        rv[p] = 1'b1;
                    end else begin
                        rv[p] = 1'b0;
                    end
                end
                rd[p] = 32'((p << 24) | ((pno[p] & 32'hFFFF) << 8) | pbeat[p]);
                rl[p] = (pbeat[p] == plen[p] - 1);
            end
            txr = ($urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
